// File: rtl/hazard_sequencer.sv
// Prioritised stall/flush sequencer: memory freeze > branch flush > load-use stall.
// Optional HAZARD_CNT_EN adds saturating StallCnt/WaitCnt statistics counters.
module hazard_sequencer #(
    parameter int FLUSH_CYC   = 1,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_rt,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_UseRt,
    input  logic       EX_BranchTaken,
    input  logic       MEM_Req,
    input  logic       MEM_Ready,
    output logic       PCWre,
    output logic       IF_ID_Wre,
    output logic       ID_EX_Wre,
    output logic       EX_MEM_Wre,
    output logic       MEM_WB_Wre,
    output logic       IF_ID_Flush,
    output logic       ControlSrc,
    output logic       MemErr
`ifdef HAZARD_CNT_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] WaitCnt
`endif
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [1:0] FC_INIT = 2'(FLUSH_CYC - 1);
    localparam logic [7:0] WC_MAX  = 8'(MEM_TIMEOUT);

    if (FLUSH_CYC < 1 || FLUSH_CYC > 2 || MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_param_check
        $error("hazard_sequencer: illegal parameter value");
    end

    logic [1:0] state, state_nxt;
    logic [1:0] fc, fc_nxt;
    logic [7:0] wc, wc_nxt;
    logic       err_set;
    logic       lu, mw, timeout, freeze, flush, stall;

    assign lu = EX_MemRead && (EX_rt != 5'd0) &&
                ((EX_rt == ID_rs) || (ID_UseRt && (EX_rt == ID_rt)));
    assign mw = MEM_Req && !MEM_Ready;

    assign timeout = (state == S_WAIT) && !MEM_Ready && (wc == WC_MAX);
    assign freeze  = mw && !timeout;
    // A branch held in EX across a freeze is flushed on the release cycle.
    assign flush   = !freeze && ((state == S_FLUSH) ||
                     (EX_BranchTaken && ((state == S_RUN) || ((state == S_WAIT) && MEM_Ready))));
    assign stall   = lu && !freeze && !flush && !timeout;

    always_comb begin
        state_nxt = state;
        fc_nxt    = fc;
        wc_nxt    = wc;
        err_set   = 1'b0;
        case (state)
            S_RUN: begin
                if (mw) begin
                    state_nxt = S_WAIT;
                    wc_nxt    = 8'd1;
                end else if (EX_BranchTaken) begin
                    state_nxt = S_FLUSH;
                    fc_nxt    = FC_INIT;
                end
            end
            S_WAIT: begin
                if (MEM_Ready) begin
                    if (EX_BranchTaken) begin
                        state_nxt = S_FLUSH;
                        fc_nxt    = FC_INIT;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end else if (wc == WC_MAX) begin
                    state_nxt = S_RUN;
                    err_set   = 1'b1;
                end else begin
                    wc_nxt = wc + 8'd1;
                end
            end
            S_FLUSH: begin
                if (mw) begin
                    state_nxt = S_WAIT;
                    wc_nxt    = 8'd1;
                end else if (fc == 2'd0) begin
                    state_nxt = S_RUN;
                end else begin
                    fc_nxt = fc - 2'd1;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state  <= S_RUN;
            fc     <= 2'd0;
            wc     <= 8'd0;
            MemErr <= 1'b0;
        end else begin
            state <= state_nxt;
            fc    <= fc_nxt;
            wc    <= wc_nxt;
            if (err_set) MemErr <= 1'b1;
        end
    end

    always_comb begin
        PCWre       = 1'b1;
        IF_ID_Wre   = 1'b1;
        ID_EX_Wre   = 1'b1;
        EX_MEM_Wre  = 1'b1;
        MEM_WB_Wre  = 1'b1;
        IF_ID_Flush = 1'b0;
        ControlSrc  = 1'b0;
        if (!Reset) begin
            {PCWre, IF_ID_Wre, ID_EX_Wre, EX_MEM_Wre, MEM_WB_Wre} = 5'b00000;
            IF_ID_Flush = 1'b1;
            ControlSrc  = 1'b1;
        end else if (freeze) begin
            {PCWre, IF_ID_Wre, ID_EX_Wre, EX_MEM_Wre, MEM_WB_Wre} = 5'b00000;
        end else if (flush) begin
            IF_ID_Flush = 1'b1;
            ControlSrc  = 1'b1;
        end else if (stall) begin
            PCWre      = 1'b0;
            IF_ID_Wre  = 1'b0;
            ControlSrc = 1'b1;
        end
    end

`ifdef HAZARD_CNT_EN
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            StallCnt <= '0;
            WaitCnt  <= '0;
        end else begin
            if (stall && (StallCnt != '1)) StallCnt <= StallCnt + 1'b1;
            if (freeze && (WaitCnt != '1)) WaitCnt <= WaitCnt + 1'b1;
        end
    end
`endif

endmodule
